// File: rtl/bt_phy_pkg.sv
// Shared BLE/Bluetooth PHY definitions: CRC engine state encoding, frame mode and
// the standard generator polynomials (implicit top term omitted).
package bt_phy_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StTail = 2'd2,
        StDone = 2'd3
    } crc_state_e;

    typedef enum logic {
        ModeAppend = 1'b0,
        ModeCheck  = 1'b1
    } crc_mode_e;

    localparam logic [7:0]  BT_HEC_POLY   = 8'hA7;
    localparam logic [23:0] BT_CRC24_POLY = 24'h00065B;
    localparam logic [15:0] CRC16_CCITT   = 16'h1021;

endpackage

// File: rtl/crc_engine_bluetooth_ble_if.sv
// Serial frame bus between the bit-serialiser/de-whitener and the CRC engine.
// master: the upstream source that frames bits; slave: the CRC engine.
interface crc_engine_bluetooth_ble_if #(
    parameter int unsigned CRC_W = 8,
    parameter int unsigned CNT_W = 14
);
    logic             mode;
    logic [CRC_W-1:0] seed;
    logic             valid_in;
    logic             data_bit;
    logic             abort;
    logic             busy;
    logic             data_out;
    logic             valid_out;
    logic             flag;
    logic [CNT_W-1:0] num_out;
    logic             done;
    logic             crc_ok;
    logic             crc_err;
    logic             len_err;

    modport master (
        output mode, seed, valid_in, data_bit, abort,
        input  busy, data_out, valid_out, flag, num_out, done, crc_ok, crc_err, len_err
    );

    modport slave (
        input  mode, seed, valid_in, data_bit, abort,
        output busy, data_out, valid_out, flag, num_out, done, crc_ok, crc_err, len_err
    );

endinterface

// File: rtl/crc_lfsr_bluetooth_ble.sv
// Bit-serial CRC LFSR. A step with load set folds the first bit into the seed
// directly, so the frame's first bit costs no extra cycle. shift_out drains the
// register MSB first with zero fill while the checksum is being appended.
module crc_lfsr_bluetooth_ble #(
    parameter int unsigned      CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CRC_W-1:0] seed,
    input  logic             step,
    input  logic             din,
    input  logic             shift_out,
    output logic [CRC_W-1:0] crc
);
    logic [CRC_W-1:0] crc_q, crc_d, base;
    logic             fb;

    // Next LFSR value: step (from seed or current), drain, or plain load.
    always_comb begin
        base  = load ? seed : crc_q;
        fb    = base[CRC_W-1] ^ din;
        crc_d = crc_q;
        if (step) begin
            crc_d = {base[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end else if (shift_out) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0};
        end else if (load) begin
            crc_d = seed;
        end
    end

    // LFSR register, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc_engine_bluetooth_ble.sv
// Bit-serial CRC/HEC engine. APPEND passes the frame through and appends the
// checksum MSB first; CHECK passes the frame through and reports the residue.
module crc_engine_bluetooth_ble
    import bt_phy_pkg::*;
#(
    parameter int unsigned      CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(BT_HEC_POLY),
    parameter int unsigned      CNT_W = 14
) (
    input logic                       clk,
    input logic                       reset,
    crc_engine_bluetooth_ble_if.slave bus
);
    localparam int unsigned      TailW  = $clog2(CRC_W + 1);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam int unsigned      MinLen = CRC_W + 1;

    crc_state_e       state_q, state_d;
    crc_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TailW-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] num_out_q, num_out_d;
    logic             data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic             flag_q, flag_d;
    logic             done_q, done_d;
    logic             crc_ok_q, crc_ok_d;
    logic             crc_err_q, crc_err_d;
    logic             len_err_q, len_err_d;

    logic             lfsr_load, lfsr_step, lfsr_shift;
    logic [CRC_W-1:0] lfsr_crc;
    logic [63:0]      total_bits;
    logic [CNT_W-1:0] total_sat;
    logic             frame_short;

    crc_lfsr_bluetooth_ble #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load      (lfsr_load),
        .seed      (bus.seed),
        .step      (lfsr_step),
        .din       (bus.data_bit),
        .shift_out (lfsr_shift),
        .crc       (lfsr_crc)
    );

    // Payload plus checksum length, clamped to what num_out can hold.
    assign total_bits  = 64'(cnt_q) + 64'(CRC_W);
    assign total_sat   = (total_bits > 64'(CntMax)) ? CntMax : CNT_W'(total_bits);
    // A CHECK frame needs at least one payload bit on top of the checksum.
    assign frame_short = 64'(cnt_q) < 64'(MinLen);

    // FSM next state, counters and registered output values.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        tail_d      = tail_q;
        num_out_d   = num_out_q;
        data_out_d  = 1'b0;
        valid_out_d = 1'b0;
        flag_d      = 1'b0;
        done_d      = 1'b0;
        crc_ok_d    = 1'b0;
        crc_err_d   = 1'b0;
        len_err_d   = len_err_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        lfsr_shift  = 1'b0;

        if (bus.abort) begin
            state_d   = StIdle;
            num_out_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.valid_in) begin
                        state_d     = StRun;
                        mode_d      = crc_mode_e'(bus.mode);
                        lfsr_load   = 1'b1;
                        lfsr_step   = 1'b1;
                        cnt_d       = CNT_W'(1);
                        num_out_d   = '0;
                        len_err_d   = 1'b0;
                        data_out_d  = bus.data_bit;
                        valid_out_d = 1'b1;
                    end
                end
                StRun: begin
                    if (bus.valid_in) begin
                        lfsr_step   = 1'b1;
                        data_out_d  = bus.data_bit;
                        valid_out_d = 1'b1;
                        if (cnt_q == CntMax) begin
                            len_err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (mode_q == ModeAppend) begin
                        // First checksum bit leaves in the same cycle the frame ends.
                        state_d     = StTail;
                        lfsr_shift  = 1'b1;
                        data_out_d  = lfsr_crc[CRC_W-1];
                        valid_out_d = 1'b1;
                        flag_d      = 1'b1;
                        tail_d      = TailW'(1);
                        num_out_d   = total_sat;
                    end else begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        num_out_d = cnt_q;
                        crc_ok_d  = (lfsr_crc == '0) && !frame_short;
                        crc_err_d = (lfsr_crc != '0) || frame_short;
                    end
                end
                StTail: begin
                    if (tail_q == TailW'(CRC_W)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        lfsr_shift  = 1'b1;
                        data_out_d  = lfsr_crc[CRC_W-1];
                        valid_out_d = 1'b1;
                        flag_d      = 1'b1;
                        tail_d      = tail_q + TailW'(1);
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            mode_q      <= ModeAppend;
            cnt_q       <= '0;
            tail_q      <= '0;
            num_out_q   <= '0;
            data_out_q  <= 1'b0;
            valid_out_q <= 1'b0;
            flag_q      <= 1'b0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            tail_q      <= tail_d;
            num_out_q   <= num_out_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            flag_q      <= flag_d;
            done_q      <= done_d;
            crc_ok_q    <= crc_ok_d;
            crc_err_q   <= crc_err_d;
            len_err_q   <= len_err_d;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.flag      = flag_q;
    assign bus.num_out   = num_out_q;
    assign bus.done      = done_q;
    assign bus.crc_ok    = crc_ok_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.len_err   = len_err_q;

endmodule

// File: tb/tb_crc_engine_bluetooth_ble.sv
// Directed bench for the BLE CRC engine: CRC-8 (poly 0x07) vectors with
// hand-computed checksums, plus a CNT_W=4 instance for counter saturation.
module tb_crc_engine_bluetooth_ble;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    crc_engine_bluetooth_ble_if #(.CRC_W(8), .CNT_W(14)) bus ();
    crc_engine_bluetooth_ble_if #(.CRC_W(8), .CNT_W(4))  bus2 ();

    crc_engine_bluetooth_ble #(.CRC_W(8), .POLY(8'h07), .CNT_W(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    crc_engine_bluetooth_ble #(.CRC_W(8), .POLY(8'h07), .CNT_W(4)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor for the main instance, sampled mid-cycle.
    logic        out_q[$];
    logic        flag_q[$];
    int          done_cnt, done_cyc, first_valid_cyc, first_flag_cyc, last_run, run_len;
    logic [13:0] num_at_flag;
    logic        done_ok, done_err, prev_valid, prev_flag;

    always @(negedge clk) begin
        if (bus.valid_out) begin
            out_q.push_back(bus.data_out);
            flag_q.push_back(bus.flag);
            if (!prev_valid) first_valid_cyc <= cyc;
            if (bus.flag && !prev_flag) begin
                first_flag_cyc <= cyc;
                num_at_flag    <= bus.num_out;
            end
            run_len <= run_len + 1;
        end else begin
            if (prev_valid) last_run <= run_len;
            run_len <= 0;
        end
        prev_valid <= bus.valid_out;
        prev_flag  <= bus.flag;
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_ok  <= bus.crc_ok;
            done_err <= bus.crc_err;
        end
    end

    function automatic logic [127:0] slice_q(input int base, input int n, input bit use_flag);
        logic [127:0] v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[126:0], use_flag ? flag_q[base+i] : out_q[base+i]};
        end
        return v;
    endfunction

    // Presents n bits (first bit = bits[n-1]); mode/seed are scrambled after the
    // first cycle so only the first-cycle sample may matter.
    task automatic drive_frame(input logic m, input logic [7:0] s, input logic [127:0] bits,
                               input int n, output int t0);
        @(posedge clk); #1;
        t0 = cyc;
        bus.mode = m;
        bus.seed = s;
        for (int i = 0; i < n; i++) begin
            bus.valid_in = 1'b1;
            bus.data_bit = bits[n-1-i];
            @(posedge clk); #1;
            bus.mode = ~m;
            bus.seed = ~s;
        end
        bus.valid_in = 1'b0;
        bus.data_bit = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int k = 0;
        while (done_cnt == base && k < 300) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL %s: done not seen, got done_cnt=%0d want >%0d", name, done_cnt, base);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        reset = 1'b0;
        bus.mode = 0; bus.seed = 0; bus.valid_in = 0; bus.data_bit = 0; bus.abort = 0;
        bus2.mode = 0; bus2.seed = 0; bus2.valid_in = 0; bus2.data_bit = 0; bus2.abort = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {bus.busy, bus.data_out, bus.valid_out, bus.flag, bus.done, bus.crc_ok,
               bus.crc_err, bus.len_err, bus.num_out};
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        checks++;
        if ({bus2.busy, bus2.valid_out, bus2.data_out, bus2.num_out} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs2: got busy=%b vo=%b num=%0d want 0",
                     bus2.busy, bus2.valid_out, bus2.num_out);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_append_byte();
        int t0, qb, db;
        qb = out_q.size();
        db = done_cnt;
        drive_frame(1'b0, 8'h00, 128'h01, 8, t0);
        wait_done(db, "append_byte");
        checks++;
        if (out_q.size() - qb !== 16) begin
            errors++;
            $display("FAIL append_byte_len: got %0d want 16", out_q.size() - qb);
        end
        checks++;
        if (slice_q(qb, 16, 0) !== 128'h0107) begin
            errors++;
            $display("FAIL append_byte_data: got %h want 0107", slice_q(qb, 16, 0));
        end
        checks++;
        if (slice_q(qb, 16, 1) !== 128'h00FF) begin
            errors++;
            $display("FAIL append_byte_flag: got %h want 00ff", slice_q(qb, 16, 1));
        end
        checks++;
        if (num_at_flag !== 14'd16) begin
            errors++;
            $display("FAIL append_byte_num: got %0d want 16", num_at_flag);
        end
        checks++;
        if (first_valid_cyc !== t0 + 1 || first_flag_cyc !== t0 + 9) begin
            errors++;
            $display("FAIL append_byte_timing: got valid@%0d flag@%0d want %0d %0d",
                     first_valid_cyc - t0, first_flag_cyc - t0, 1, 9);
        end
        checks++;
        if (done_cyc !== t0 + 17 || done_cnt - db !== 1) begin
            errors++;
            $display("FAIL append_byte_done: got at +%0d count %0d want +17 count 1",
                     done_cyc - t0, done_cnt - db);
        end
        checks++;
        if (last_run !== 16 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL append_byte_run: got run=%0d busy=%b want 16 0", last_run, bus.busy);
        end
    endtask

    task automatic test_append_string();
        int t0, qb, db;
        qb = out_q.size();
        db = done_cnt;
        drive_frame(1'b0, 8'h00, 128'h313233343536373839, 72, t0);
        wait_done(db, "append_string");
        checks++;
        if (slice_q(qb, 80, 0) !== 128'h313233343536373839F4) begin
            errors++;
            $display("FAIL append_string_data: got %h want 313233343536373839f4",
                     slice_q(qb, 80, 0));
        end
        checks++;
        if (last_run !== 80 || num_at_flag !== 14'd80) begin
            errors++;
            $display("FAIL append_string_len: got run=%0d num=%0d want 80 80",
                     last_run, num_at_flag);
        end
    endtask

    task automatic test_check();
        int t0, qb, db;
        logic [127:0] frame;
        frame = 128'h313233343536373839F4;
        qb = out_q.size();
        db = done_cnt;
        drive_frame(1'b1, 8'h00, frame, 80, t0);
        wait_done(db, "check_good");
        checks++;
        if (done_ok !== 1'b1 || done_err !== 1'b0 || done_cyc !== t0 + 81) begin
            errors++;
            $display("FAIL check_good: got ok=%b err=%b at +%0d want 1 0 +81",
                     done_ok, done_err, done_cyc - t0);
        end
        checks++;
        if (slice_q(qb, 80, 0) !== frame || slice_q(qb, 80, 1) !== 128'h0
            || out_q.size() - qb !== 80) begin
            errors++;
            $display("FAIL check_passthru: got %h (%0d bits) want %h",
                     slice_q(qb, 80, 0), out_q.size() - qb, frame);
        end
        db = done_cnt;
        drive_frame(1'b1, 8'h00, frame ^ (128'h1 << 74), 80, t0);
        wait_done(db, "check_flip");
        checks++;
        if (done_ok !== 1'b0 || done_err !== 1'b1) begin
            errors++;
            $display("FAIL check_flip: got ok=%b err=%b want 0 1", done_ok, done_err);
        end
        db = done_cnt;
        drive_frame(1'b1, 8'h00, 128'h0, 5, t0);
        wait_done(db, "check_short");
        checks++;
        if (done_ok !== 1'b0 || done_err !== 1'b1) begin
            errors++;
            $display("FAIL check_short: got ok=%b err=%b want 0 1", done_ok, done_err);
        end
    endtask

    task automatic test_back_to_back();
        int ta, tb, qb, db;
        qb = out_q.size();
        db = done_cnt;
        drive_frame(1'b0, 8'h00, 128'h01, 8, ta);
        repeat (9) @(posedge clk);
        // Frame B starts the cycle after A's done pulse.
        drive_frame(1'b1, 8'h01, 128'h0007, 16, tb);
        wait_done(db + 1, "back_to_back");
        checks++;
        if (done_cnt - db !== 2 || tb - ta !== 18) begin
            errors++;
            $display("FAIL b2b_done: got %0d dones, gap %0d want 2 18", done_cnt - db, tb - ta);
        end
        checks++;
        if (slice_q(qb, 32, 0) !== 128'h01070007) begin
            errors++;
            $display("FAIL b2b_data: got %h want 01070007", slice_q(qb, 32, 0));
        end
        checks++;
        if (done_ok !== 1'b1 || done_err !== 1'b0 || done_cyc !== tb + 17) begin
            errors++;
            $display("FAIL b2b_check: got ok=%b err=%b at +%0d want 1 0 +17",
                     done_ok, done_err, done_cyc - tb);
        end
    endtask

    task automatic test_abort();
        int t0, qb, db;
        qb = out_q.size();
        db = done_cnt;
        drive_frame(1'b0, 8'h00, 128'h01, 8, t0);
        repeat (3) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.valid_out, bus.flag, bus.data_out, bus.busy} !== 4'b0) begin
            errors++;
            $display("FAIL abort_outputs: got vo=%b fl=%b do=%b busy=%b want 0",
                     bus.valid_out, bus.flag, bus.data_out, bus.busy);
        end
        repeat (30) @(posedge clk);
        checks++;
        if (done_cnt !== db || out_q.size() - qb !== 11 || slice_q(qb, 11, 0) !== 128'h008) begin
            errors++;
            $display("FAIL abort_frame: got dones=%0d bits=%0d data=%h want 0 11 008",
                     done_cnt - db, out_q.size() - qb, slice_q(qb, 11, 0));
        end
        qb = out_q.size();
        db = done_cnt;
        drive_frame(1'b0, 8'h00, 128'h01, 8, t0);
        wait_done(db, "abort_next");
        checks++;
        if (slice_q(qb, 16, 0) !== 128'h0107) begin
            errors++;
            $display("FAIL abort_next: got %h want 0107", slice_q(qb, 16, 0));
        end
    endtask

    task automatic test_reset_mid_run();
        int t0, qb, db;
        logic [21:0] obs;
        @(posedge clk); #1;
        bus.mode = 1'b0;
        bus.seed = 8'h5A;
        bus.valid_in = 1'b1;
        bus.data_bit = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy: got busy=%b vo=%b want 1 1", bus.busy, bus.valid_out);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        obs = {bus.busy, bus.data_out, bus.valid_out, bus.flag, bus.done, bus.crc_ok,
               bus.crc_err, bus.len_err, bus.num_out};
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL midrun_reset: got %h want 0", obs);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_bit = 1'b0;
        qb = out_q.size();
        db = done_cnt;
        drive_frame(1'b0, 8'h00, 128'h01, 8, t0);
        wait_done(db, "midrun_next");
        checks++;
        if (slice_q(qb, 16, 0) !== 128'h0107) begin
            errors++;
            $display("FAIL midrun_next: got %h want 0107", slice_q(qb, 16, 0));
        end
    endtask

    task automatic test_len_sat();
        logic [7:0] crc_got;
        logic [3:0] num_got;
        logic       len_got, flag_got;
        crc_got = '0;
        @(posedge clk); #1;
        bus2.mode = 1'b0;
        bus2.seed = 8'h00;
        // 0x01 followed by 12 zero bits: CRC-8/0x07 = 0x57.
        for (int i = 0; i < 20; i++) begin
            bus2.valid_in = 1'b1;
            bus2.data_bit = (i == 7);
            @(posedge clk); #1;
        end
        bus2.valid_in = 1'b0;
        bus2.data_bit = 1'b0;
        num_got = '0;
        len_got = 1'b0;
        flag_got = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 0) begin
                num_got  = bus2.num_out;
                len_got  = bus2.len_err;
                flag_got = bus2.flag;
            end
            crc_got = {crc_got[6:0], bus2.data_out};
        end
        checks++;
        if (crc_got !== 8'h57) begin
            errors++;
            $display("FAIL sat_crc: got %h want 57", crc_got);
        end
        checks++;
        if (num_got !== 4'd15 || len_got !== 1'b1 || flag_got !== 1'b1) begin
            errors++;
            $display("FAIL sat_num: got num=%0d len_err=%b flag=%b want 15 1 1",
                     num_got, len_got, flag_got);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus2.done !== 1'b1) begin
            errors++;
            $display("FAIL sat_done: got %b want 1", bus2.done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus2.len_err !== 1'b1 || bus2.busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_sticky: got len_err=%b busy=%b want 1 0", bus2.len_err, bus2.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        done_cnt = 0;
        run_len = 0;
        last_run = 0;
        prev_valid = 1'b0;
        prev_flag = 1'b0;
        test_reset();
        test_append_byte();
        test_append_string();
        test_check();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        test_len_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
